// File: rtl/uart_baud_gen.sv
// UART baud tick generator: fractional oversample divider (rx_tick) and bit tick (tx_tick),
// with divisor changes deferred to bit boundaries so no bit is split between two rates.
module uart_baud_gen #(
    parameter int DIV_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 325,
    parameter int RESET_DIV_FRAC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic             div_load,
    output logic             rx_tick,
    output logic             tx_tick,
    output logic             div_pending,
    output logic             cfg_err,
    output logic [DIV_W-1:0] active_div_int
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_DIV_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_DIV_FRAC);

    logic [DIV_W-1:0]  r_rx_cnt;
    logic [OS_W-1:0]   r_os_cnt;
    logic [FRAC_W-1:0] r_frac_acc;
    logic              r_extra;
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pending;
    logic              r_rx_tick;
    logic              r_tx_tick;
    logic              r_cfg_err;

    logic [DIV_W:0]    w_term_cnt;
    logic              w_term;
    logic              w_bit;
    logic              w_load_ok;
    logic              w_load_bad;
    logic [FRAC_W:0]   w_frac_sum;

    // Period length is active_int + extra; the terminal count is one less than that.
    assign w_term_cnt = {1'b0, r_act_int} + {{DIV_W{1'b0}}, r_extra} - {{DIV_W{1'b0}}, 1'b1};
    assign w_term     = enable && ({1'b0, r_rx_cnt} == w_term_cnt);
    assign w_bit      = w_term && (r_os_cnt == OS_LAST);
    assign w_load_ok  = div_load && (div_int >= DIV_W'(2));
    assign w_load_bad = div_load && (div_int <  DIV_W'(2));
    assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, r_act_frac};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_os_cnt   <= '0;
            r_frac_acc <= '0;
            r_extra    <= 1'b0;
            r_act_int  <= RST_INT;
            r_act_frac <= RST_FRAC;
            r_sh_int   <= RST_INT;
            r_sh_frac  <= RST_FRAC;
            r_pending  <= 1'b0;
            r_rx_tick  <= 1'b0;
            r_tx_tick  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_rx_tick <= w_term;
            r_tx_tick <= w_bit;
            r_cfg_err <= w_load_bad;

            if (!enable) begin
                r_rx_cnt   <= '0;
                r_os_cnt   <= '0;
                r_frac_acc <= '0;
                r_extra    <= 1'b0;
                // A load still waiting for a boundary takes effect as soon as we stop.
                if (r_pending) begin
                    r_act_int  <= r_sh_int;
                    r_act_frac <= r_sh_frac;
                    r_pending  <= 1'b0;
                end
            end else if (w_term) begin
                r_rx_cnt <= '0;
                r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
                if (w_bit && r_pending) begin
                    r_act_int  <= r_sh_int;
                    r_act_frac <= r_sh_frac;
                    r_pending  <= 1'b0;
                    r_frac_acc <= '0;
                    r_extra    <= 1'b0;
                end else begin
                    r_frac_acc <= w_frac_sum[FRAC_W-1:0];
                    r_extra    <= w_frac_sum[FRAC_W];
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + DIV_W'(1);
            end

            // Placed last so a load coinciding with a boundary re-arms the shadow.
            if (w_load_ok) begin
                if (!enable) begin
                    r_act_int  <= div_int;
                    r_act_frac <= div_frac;
                end else begin
                    r_sh_int   <= div_int;
                    r_sh_frac  <= div_frac;
                    r_pending  <= 1'b1;
                end
            end
        end
    end

    assign rx_tick        = r_rx_tick;
    assign tx_tick        = r_tx_tick;
    assign div_pending    = r_pending;
    assign cfg_err        = r_cfg_err;
    assign active_div_int = r_act_int;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: two instances (OVERSAMPLE 16 and 4) share stimulus and are
// compared every cycle against a tick-schedule model, plus literal timing expectations.
module tb_uart_baud_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;

    logic        w_rx   [2];
    logic        w_tx   [2];
    logic        w_pend [2];
    logic        w_err  [2];
    logic [15:0] w_act  [2];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    uart_baud_gen u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .rx_tick(w_rx[0]), .tx_tick(w_tx[0]), .div_pending(w_pend[0]),
        .cfg_err(w_err[0]), .active_div_int(w_act[0])
    );

    uart_baud_gen #(.OVERSAMPLE(4)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .rx_tick(w_rx[1]), .tx_tick(w_tx[1]), .div_pending(w_pend[1]),
        .cfg_err(w_err[1]), .active_div_int(w_act[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, i, $time, got, exp);
        end
    endtask

    // Model: each instance keeps the absolute edge number of its next rx tick.
    int edge_n = 0;
    int m_act [2], m_actf [2], m_sh [2], m_shf [2];
    bit m_pend [2], m_run [2];
    int m_due [2], m_ntick [2], m_nT [2];
    bit e_rx [2], e_tx [2], e_err [2];

    function automatic int os_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            int extra;
            e_rx[i] = 0; e_tx[i] = 0; e_err[i] = 0;
            if (reset) begin
                m_act[i] = 325; m_actf[i] = 8; m_sh[i] = 325; m_shf[i] = 8;
                m_pend[i] = 0; m_run[i] = 0; m_ntick[i] = 0; m_nT[i] = 0; m_due[i] = 0;
            end else begin
                if (!enable) begin
                    m_run[i] = 0; m_ntick[i] = 0; m_nT[i] = 0;
                    if (m_pend[i]) begin
                        m_act[i] = m_sh[i]; m_actf[i] = m_shf[i]; m_pend[i] = 0;
                    end
                end else if (!m_run[i]) begin
                    m_run[i] = 1;
                    m_due[i] = edge_n + m_act[i] - 1;
                end else if (edge_n == m_due[i]) begin
                    e_rx[i] = 1;
                    e_tx[i] = ((m_ntick[i] % os_of(i)) == os_of(i) - 1);
                    m_ntick[i]++;
                    // Extra clock whenever the running fractional total crosses a whole clock.
                    extra = ((m_nT[i] + 1) * m_actf[i]) / 16 - (m_nT[i] * m_actf[i]) / 16;
                    m_nT[i]++;
                    if (e_tx[i] && m_pend[i]) begin
                        m_act[i] = m_sh[i]; m_actf[i] = m_shf[i]; m_pend[i] = 0;
                        m_nT[i] = 0; extra = 0;
                    end
                    m_due[i] = edge_n + m_act[i] + extra;
                end
                if (div_load) begin
                    if (div_int < 2) e_err[i] = 1;
                    else if (!enable) begin
                        m_act[i] = int'(div_int); m_actf[i] = int'(div_frac);
                    end else begin
                        m_sh[i] = int'(div_int); m_shf[i] = int'(div_frac); m_pend[i] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("rx_tick",     i, 32'(w_rx[i]),   32'(e_rx[i]));
                check("tx_tick",     i, 32'(w_tx[i]),   32'(e_tx[i]));
                check("div_pending", i, 32'(w_pend[i]), 32'(m_pend[i]));
                check("cfg_err",     i, 32'(w_err[i]),  32'(e_err[i]));
                check("active_div",  i, 32'(w_act[i]),  32'(m_act[i]));
            end
        end
    end

    task automatic wait_ev(input int i, input bit want_tx, input int bound, output int n);
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            seen = want_tx ? w_tx[i] : w_rx[i];
        end
        if (want_tx) check("wait_tx", i, 32'(seen), 32'd1);
        else         check("wait_rx", i, 32'(seen), 32'd1);
    endtask

    task automatic load_div(input int di, input int df, input bit en);
        enable = en; div_load = 1'b1; div_int = 16'(di); div_frac = 4'(df);
        @(negedge clk);
        div_load = 1'b0;
    endtask

    initial begin
        int n, tot, txc, txidx;
        int per [6];
        reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("reset_act",  0, 32'(w_act[0]),  32'd325);
        check("reset_rx",   0, 32'(w_rx[0]),   32'd0);
        check("reset_pend", 1, 32'(w_pend[1]), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Default divisor 325 + 8/16.
        enable = 1'b1;
        wait_ev(0, 0, 400, n);
        check("first_rx_latency", 0, 32'(n), 32'd325);
        check("inst1_rx_aligned", 1, 32'(w_rx[1]), 32'd1);
        tot = n; txc = 0; txidx = 0;
        for (int k = 2; k <= 32; k++) begin
            wait_ev(0, 0, 400, n);
            if (k <= 5) per[k] = n;
            tot += n;
            if (w_tx[0]) begin txc++; if (txidx == 0) txidx = k; end
        end
        check("period2", 0, 32'(per[2]), 32'd325);
        check("period3", 0, 32'(per[3]), 32'd326);
        check("period4", 0, 32'(per[4]), 32'd325);
        check("period5", 0, 32'(per[5]), 32'd326);
        check("span32",  0, 32'(tot),    32'd10415);
        check("tx_count32", 0, 32'(txc), 32'd2);
        check("tx_first_index", 0, 32'(txidx), 32'd16);

        // Integer divisor 5 loaded while idle.
        enable = 1'b0;
        @(negedge clk);
        load_div(5, 0, 1'b0);
        check("idle_load_act", 1, 32'(w_act[1]), 32'd5);
        enable = 1'b1;
        wait_ev(1, 0, 20, n);
        check("rx_latency_5", 1, 32'(n), 32'd5);
        wait_ev(1, 0, 20, n);
        check("rx_period_5", 1, 32'(n), 32'd5);
        wait_ev(1, 1, 40, n);
        check("first_tx_os4", 1, 32'(n), 32'd10);
        wait_ev(1, 1, 40, n);
        check("tx_period_os4", 1, 32'(n), 32'd20);

        // 5 + 8/16 over 1000 ticks.
        enable = 1'b0;
        @(negedge clk);
        load_div(5, 8, 1'b0);
        enable = 1'b1;
        tot = 0;
        for (int k = 1; k <= 1000; k++) begin
            wait_ev(0, 0, 20, n);
            if (k <= 5) per[k] = n;
            tot += n;
        end
        check("frac_p1", 0, 32'(per[1]), 32'd5);
        check("frac_p2", 0, 32'(per[2]), 32'd5);
        check("frac_p3", 0, 32'(per[3]), 32'd6);
        check("frac_p4", 0, 32'(per[4]), 32'd5);
        check("frac_p5", 0, 32'(per[5]), 32'd6);
        check("span1000", 0, 32'(tot), 32'd5499);

        // Deferred load at a bit boundary; second load wins.
        enable = 1'b0;
        @(negedge clk);
        load_div(5, 0, 1'b0);
        enable = 1'b1;
        wait_ev(1, 0, 20, n);
        wait_ev(1, 0, 20, n);
        load_div(7, 0, 1'b1);
        load_div(3, 0, 1'b1);
        check("pending_set", 1, 32'(w_pend[1]), 32'd1);
        check("act_before_b", 1, 32'(w_act[1]), 32'd5);
        wait_ev(1, 1, 40, n);
        check("pending_clear", 1, 32'(w_pend[1]), 32'd0);
        check("act_after_b",   1, 32'(w_act[1]),  32'd3);
        wait_ev(1, 0, 20, n);
        check("new_period_a", 1, 32'(n), 32'd3);
        wait_ev(1, 0, 20, n);
        check("new_period_b", 1, 32'(n), 32'd3);

        // Illegal divisors.
        div_load = 1'b1; div_int = 16'd1;
        @(negedge clk);
        div_int = 16'd0;
        check("cfg_err_1", 1, 32'(w_err[1]), 32'd1);
        @(negedge clk);
        div_load = 1'b0;
        check("cfg_err_0", 1, 32'(w_err[1]), 32'd1);
        @(negedge clk);
        check("cfg_err_end", 1, 32'(w_err[1]), 32'd0);
        check("cfg_act",     1, 32'(w_act[1]), 32'd3);
        wait_ev(1, 0, 20, n);
        wait_ev(1, 0, 20, n);
        check("cfg_period", 1, 32'(n), 32'd3);

        // Enable drop mid-period.
        wait_ev(1, 0, 20, n);
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("low_rx", 1, 32'(w_rx[1]), 32'd0);
            check("low_tx", 1, 32'(w_tx[1]), 32'd0);
        end
        enable = 1'b1;
        wait_ev(1, 0, 20, n);
        check("reenable_latency", 1, 32'(n), 32'd3);

        // Reset with a pending load.
        load_div(9, 3, 1'b1);
        check("pend_before_reset", 1, 32'(w_pend[1]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_pend_clr", 1, 32'(w_pend[1]), 32'd0);
        check("reset_act1",     1, 32'(w_act[1]),  32'd325);
        check("reset_act0",     0, 32'(w_act[0]),  32'd325);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            reset    = ($urandom_range(0, 499) == 0);
            enable   = ($urandom_range(0, 79) != 0);
            div_load = ($urandom_range(0, 29) == 0);
            div_int  = 16'($urandom_range(0, 9));
            div_frac = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        reset = 1'b0; div_load = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
